// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: shared opcodes, ALU codes, mux encodings, FSM states and control vector
// for the multicycle MIPS controller.
// Optional feature macro: JUMP_EN (adds the JUMP state and makes opcode 000010 legal).
package multicycle_control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_AND   = 3'd0;
    localparam logic [2:0] ALU_OR    = 3'd1;
    localparam logic [2:0] ALU_ADD   = 3'd2;
    localparam logic [2:0] ALU_SUB   = 3'd3;
    localparam logic [2:0] ALU_FUNCT = 3'd4;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, RTYPE_EX, RTYPE_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR,
        BRANCH, IMM_EX, IMM_WB
`ifdef JUMP_EN
        , JUMP
`endif
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
        logic       illegal_op;
    } ctrl_t;

    // State that follows DECODE; FETCH doubles as the "unknown opcode" answer.
    function automatic state_t decode_target(input logic [5:0] op);
        case (op)
            OP_RTYPE:             return RTYPE_EX;
            OP_LW, OP_SW:         return MEM_ADDR;
            OP_BEQ:               return BRANCH;
            OP_ADDI, OP_ANDI,
            OP_ORI:               return IMM_EX;
`ifdef JUMP_EN
            OP_J:                 return JUMP;
`endif
            default:              return FETCH;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: combinational state/opcode -> datapath control vector.
// Ports: i_state (current FSM state), i_opcode (live in DECODE, latched elsewhere),
//        i_mem_ready (gates ir_write/pc_write in FETCH), o_ctrl (control vector).
// Optional feature macro: JUMP_EN (decodes the JUMP state).
module mc_ctrl_decode
    import multicycle_control_pkg::*;
(
    input  state_t     i_state,
    input  logic [5:0] i_opcode,
    input  logic       i_mem_ready,
    output ctrl_t      o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.alu_op    = ALU_ADD;
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            DECODE: begin
                o_ctrl.alu_src_b  = SRCB_IMMSH;
                o_ctrl.alu_op     = ALU_ADD;
                o_ctrl.illegal_op = decode_target(i_opcode) == FETCH;
            end
            RTYPE_EX: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_REGB;
                o_ctrl.alu_op    = ALU_FUNCT;
            end
            RTYPE_WB: begin
                o_ctrl.reg_dst   = 1'b1;
                o_ctrl.reg_write = 1'b1;
            end
            MEM_ADDR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALU_ADD;
            end
            MEM_RD: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.iord     = 1'b1;
            end
            MEM_WB: begin
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.reg_write  = 1'b1;
            end
            MEM_WR: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.iord      = 1'b1;
            end
            BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_src_b     = SRCB_REGB;
                o_ctrl.alu_op        = ALU_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = PCSRC_ALUOUT;
            end
            IMM_EX: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = (i_opcode == OP_ANDI) ? ALU_AND :
                                   (i_opcode == OP_ORI)  ? ALU_OR  : ALU_ADD;
            end
            IMM_WB: begin
                o_ctrl.reg_write = 1'b1;
            end
`ifdef JUMP_EN
            JUMP: begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = PCSRC_JUMP;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS controller FSM (FETCH/DECODE/EXEC/MEM/WB, shared memory).
// Ports: i_clk, i_reset (async, active-high), i_opcode (IR[31:26], sampled in DECODE),
//        i_mem_ready (memory access completes), o_* datapath selects/enables, o_alu_op,
//        o_illegal_op (pulse on unknown opcode in DECODE), o_state (debug).
// Optional feature macro: JUMP_EN (j instruction via JUMP state; otherwise 000010 is illegal).
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 3,
    parameter int STATE_W  = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [OPCODE_W-1:0] i_opcode,
    input  logic                i_mem_ready,
    output logic                o_pc_write,
    output logic                o_pc_write_cond,
    output logic                o_iord,
    output logic                o_mem_read,
    output logic                o_mem_write,
    output logic                o_ir_write,
    output logic                o_mem_to_reg,
    output logic                o_reg_dst,
    output logic                o_reg_write,
    output logic                o_alu_src_a,
    output logic [1:0]          o_alu_src_b,
    output logic [1:0]          o_pc_source,
    output logic [ALUOP_W-1:0]  o_alu_op,
    output logic                o_illegal_op,
    output logic [STATE_W-1:0]  o_state
);

    state_t     r_state;
    logic [5:0] r_opcode;
    logic [5:0] w_op;
    ctrl_t      w_ctrl;

    // The live opcode matters only in DECODE; later states use the copy captured there.
    assign w_op = (r_state == DECODE) ? 6'(i_opcode) : r_opcode;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= IDLE;
            r_opcode <= '0;
        end else begin
            if (r_state == DECODE) r_opcode <= w_op;
            case (r_state)
                IDLE:     r_state <= FETCH;
                FETCH:    r_state <= i_mem_ready ? DECODE : FETCH;
                DECODE:   r_state <= decode_target(w_op);
                RTYPE_EX: r_state <= RTYPE_WB;
                MEM_ADDR: r_state <= (w_op == OP_LW) ? MEM_RD : MEM_WR;
                MEM_RD:   r_state <= i_mem_ready ? MEM_WB : MEM_RD;
                MEM_WR:   r_state <= i_mem_ready ? FETCH : MEM_WR;
                IMM_EX:   r_state <= IMM_WB;
                RTYPE_WB, MEM_WB, BRANCH, IMM_WB
`ifdef JUMP_EN
                , JUMP
`endif
                          : r_state <= FETCH;
                default:  r_state <= IDLE;
            endcase
        end
    end

    mc_ctrl_decode u_decode (
        .i_state     (r_state),
        .i_opcode    (w_op),
        .i_mem_ready (i_mem_ready),
        .o_ctrl      (w_ctrl)
    );

    assign o_pc_write      = w_ctrl.pc_write;
    assign o_pc_write_cond = w_ctrl.pc_write_cond;
    assign o_iord          = w_ctrl.iord;
    assign o_mem_read      = w_ctrl.mem_read;
    assign o_mem_write     = w_ctrl.mem_write;
    assign o_ir_write      = w_ctrl.ir_write;
    assign o_mem_to_reg    = w_ctrl.mem_to_reg;
    assign o_reg_dst       = w_ctrl.reg_dst;
    assign o_reg_write     = w_ctrl.reg_write;
    assign o_alu_src_a     = w_ctrl.alu_src_a;
    assign o_alu_src_b     = w_ctrl.alu_src_b;
    assign o_pc_source     = w_ctrl.pc_source;
    assign o_alu_op        = ALUOP_W'(w_ctrl.alu_op);
    assign o_illegal_op    = w_ctrl.illegal_op;
    assign o_state         = STATE_W'(r_state);

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed instruction sequences against a per-instruction phase model.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    typedef struct packed {
        logic pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, sa;
        logic [1:0] sb, ps;
        logic [2:0] aop;
        logic ill;
        logic [3:0] st;
    } exp_t;

    typedef struct packed {
        logic       rdy;
        logic [5:0] op;
        exp_t       e;
    } cyc_t;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic [5:0] i_opcode = '0;
    logic       i_mem_ready = 1'b0;
    logic       o_pc_write, o_pc_write_cond, o_iord, o_mem_read, o_mem_write, o_ir_write;
    logic       o_mem_to_reg, o_reg_dst, o_reg_write, o_alu_src_a, o_illegal_op;
    logic [1:0] o_alu_src_b, o_pc_source;
    logic [2:0] o_alu_op;
    logic [3:0] o_state;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    cyc_t q[$];

    multicycle_control dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_opcode(i_opcode), .i_mem_ready(i_mem_ready),
        .o_pc_write(o_pc_write), .o_pc_write_cond(o_pc_write_cond), .o_iord(o_iord),
        .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_ir_write(o_ir_write),
        .o_mem_to_reg(o_mem_to_reg), .o_reg_dst(o_reg_dst), .o_reg_write(o_reg_write),
        .o_alu_src_a(o_alu_src_a), .o_alu_src_b(o_alu_src_b), .o_pc_source(o_pc_source),
        .o_alu_op(o_alu_op), .o_illegal_op(o_illegal_op), .o_state(o_state)
    );

    always #5 i_clk = ~i_clk;

    function automatic exp_t ph(input state_t s);
        exp_t e;
        e = '0;
        e.st = s;
        return e;
    endfunction

    task automatic add(input logic rdy, input logic [5:0] op, input exp_t e);
        q.push_back({rdy, op, e});
    endtask

    // Expected cycle list for one instruction; opcode is driven to garbage outside DECODE.
    task automatic add_instr(input logic [5:0] op, input int fw, input int mw);
        exp_t e;
        logic [5:0] x;
        x = ~op;
        e = ph(FETCH);
        e.mr = 1'b1;
        e.sb = 2'b01;
        e.aop = 3'd2;
        repeat (fw) add(1'b0, x, e);
        e.irw = 1'b1;
        e.pcw = 1'b1;
        add(1'b1, x, e);
        e = ph(DECODE);
        e.sb = 2'b11;
        e.aop = 3'd2;
        if (op == 6'b000000) begin
            add(1'b0, op, e);
            e = ph(RTYPE_EX); e.sa = 1'b1; e.aop = 3'd4; add(1'b0, x, e);
            e = ph(RTYPE_WB); e.rdst = 1'b1; e.rw = 1'b1; add(1'b0, x, e);
        end else if (op == 6'b100011 || op == 6'b101011) begin
            add(1'b0, op, e);
            e = ph(MEM_ADDR); e.sa = 1'b1; e.sb = 2'b10; e.aop = 3'd2; add(1'b0, x, e);
            e = ph(op == 6'b100011 ? MEM_RD : MEM_WR);
            e.iord = 1'b1;
            if (op == 6'b100011) e.mr = 1'b1; else e.mw = 1'b1;
            repeat (mw) add(1'b0, x, e);
            add(1'b1, x, e);
            if (op == 6'b100011) begin
                e = ph(MEM_WB); e.m2r = 1'b1; e.rw = 1'b1; add(1'b0, x, e);
            end
        end else if (op == 6'b000100) begin
            add(1'b0, op, e);
            e = ph(BRANCH); e.sa = 1'b1; e.aop = 3'd3; e.pcwc = 1'b1; e.ps = 2'b01;
            add(1'b0, x, e);
        end else if (op == 6'b001000 || op == 6'b001100 || op == 6'b001101) begin
            add(1'b0, op, e);
            e = ph(IMM_EX); e.sa = 1'b1; e.sb = 2'b10;
            e.aop = (op == 6'b001000) ? 3'd2 : (op == 6'b001100) ? 3'd0 : 3'd1;
            add(1'b0, x, e);
            e = ph(IMM_WB); e.rw = 1'b1; add(1'b0, x, e);
        end
`ifdef JUMP_EN
        else if (op == 6'b000010) begin
            add(1'b0, op, e);
            e = ph(JUMP); e.pcw = 1'b1; e.ps = 2'b10; add(1'b0, x, e);
        end
`endif
        else begin
            e.ill = 1'b1;
            add(1'b0, op, e);
        end
    endtask

    // Pins the model's cycle count for an instruction to a hand-computed latency.
    task automatic add_pinned(input logic [5:0] op, input int fw, input int mw, input int lat);
        int n0;
        n0 = q.size();
        add_instr(op, fw, mw);
        checks++;
        if (q.size() - n0 != lat) begin
            errors++;
            $display("FAIL latency op=%b got %0d want %0d", op, q.size() - n0, lat);
        end
    endtask

    task automatic cmp(input exp_t e);
        exp_t a;
        a = {o_pc_write, o_pc_write_cond, o_iord, o_mem_read, o_mem_write, o_ir_write,
             o_mem_to_reg, o_reg_dst, o_reg_write, o_alu_src_a, o_alu_src_b, o_pc_source,
             o_alu_op, o_illegal_op, o_state};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL outputs cyc%0d got %h want %h", cyc, a, e);
        end
    endtask

    task automatic run_q();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            i_mem_ready = c.rdy;
            i_opcode = c.op;
            #1 cmp(c.e);
            cyc++;
            @(negedge i_clk);
        end
    endtask

    initial begin
        repeat (3) @(negedge i_clk);
        #1 cmp(ph(IDLE));
        @(negedge i_clk);
        i_reset = 1'b0;
        add(1'b0, 6'b111111, ph(IDLE));
        add_pinned(6'b000000, 0, 0, 4);
        add_pinned(6'b100011, 0, 2, 7);
        add_pinned(6'b101011, 0, 0, 4);
        add_pinned(6'b101011, 1, 1, 6);
        add_pinned(6'b000100, 0, 0, 3);
        add_pinned(6'b001000, 0, 0, 4);
        add_pinned(6'b001100, 2, 0, 6);
        add_pinned(6'b001101, 0, 0, 4);
        add_pinned(6'b111111, 0, 0, 2);
`ifdef JUMP_EN
        add_pinned(6'b000010, 0, 0, 3);
`else
        add_pinned(6'b000010, 0, 0, 2);
`endif
        add_pinned(6'b100011, 0, 0, 5);
        add_pinned(6'b000000, 1, 0, 5);
        add_instr(6'b101011, 0, 3);
        void'(q.pop_back());
        run_q();
        i_mem_ready = 1'b0;
        #1;
        checks++;
        if (o_mem_write !== 1'b1) begin
            errors++;
            $display("FAIL mw_before_reset got %b want 1", o_mem_write);
        end
        #1 i_reset = 1'b1;
        #1 cmp(ph(IDLE));
        @(negedge i_clk);
        #1 cmp(ph(IDLE));
        i_reset = 1'b0;
        add(1'b0, 6'b000000, ph(IDLE));
        add_instr(6'b000100, 0, 0);
        add_instr(6'b100011, 1, 1);
        run_q();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
